// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR MAC sequencer.
package fir_seq_pkg;
  localparam int FIR_N_DEF      = 41;
  localparam int FIR_DP_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HOLD
  } seq_state_e;
endpackage

// File: rtl/fir_seq_mod_ctr.sv
// Modulo-N up counter with enable and synchronous clear; never leaves 0..N-1.
module fir_seq_mod_ctr #(
  parameter int N = 41,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic at_top;
  assign at_top = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= at_top ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed N-tap FIR: sample RAM, coef ROM and MAC.
// Optional FIR_SEQ_PERF_EN adds a saturating input-stall counter (stall_cnt).
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int N      = FIR_N_DEF,
  parameter int DP_LAT = FIR_DP_LAT_DEF,
  parameter int AW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sample_we,
  output logic          sample_zero,
  output logic [AW-1:0] sample_waddr,
  output logic [AW-1:0] sample_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          result_load,
  output logic          busy
`ifdef FIR_SEQ_PERF_EN
  ,output logic [15:0]  stall_cnt
`endif
);
  localparam int DW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  seq_state_e    state, state_nx;
  logic [AW-1:0] wptr, tap, init_addr, newest;
  logic [DW-1:0] drain_cnt;
  logic          tap_last, init_last, drain_last, hs;
  logic          rdy_c, we_c, zero_c, clr_c, en_c, load_c, ov_c;
  logic [AW-1:0] waddr_c;

  assign tap_last   = (tap == AW'(N - 1));
  assign init_last  = (init_addr == AW'(N - 1));
  assign drain_last = (drain_cnt == DW'(DP_LAT - 1));

  fir_seq_mod_ctr #(.N(N), .W(AW)) u_wptr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(hs), .cnt(wptr)
  );
  fir_seq_mod_ctr #(.N(N), .W(AW)) u_tap (
    .clk(clk), .rst_n(rst_n), .clr(state != S_RUN), .en(state == S_RUN), .cnt(tap)
  );
  fir_seq_mod_ctr #(.N(N), .W(AW)) u_init (
    .clk(clk), .rst_n(rst_n), .clr(state != S_INIT), .en(state == S_INIT), .cnt(init_addr)
  );
  fir_seq_mod_ctr #(.N(DP_LAT), .W(DW)) u_drain (
    .clk(clk), .rst_n(rst_n), .clr(state != S_DRAIN), .en(state == S_DRAIN), .cnt(drain_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_INIT;
      newest <= '0;
    end else begin
      state <= state_nx;
      if (hs) newest <= wptr;
    end
  end

  always_comb begin
    state_nx = state;
    rdy_c    = 1'b0;
    we_c     = 1'b0;
    zero_c   = 1'b0;
    waddr_c  = wptr;
    clr_c    = 1'b0;
    en_c     = 1'b0;
    load_c   = 1'b0;
    ov_c     = 1'b0;
    case (state)
      S_INIT: begin
        we_c    = 1'b1;
        zero_c  = 1'b1;
        waddr_c = init_addr;
        if (init_last) state_nx = S_IDLE;
      end
      S_IDLE: begin
        rdy_c = 1'b1;
        if (in_valid) begin
          we_c     = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        en_c  = 1'b1;
        clr_c = (tap == '0);
        if (tap_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) begin
          load_c   = 1'b1;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        ov_c  = 1'b1;
        rdy_c = out_ready;
        // result leaves and a new sample may enter in the same cycle
        if (out_ready) begin
          we_c     = in_valid;
          state_nx = in_valid ? S_RUN : S_IDLE;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  assign hs = rst_n & rdy_c & in_valid;

  // Strobes are forced low while reset is held, regardless of the stale state.
  assign in_ready     = rst_n & rdy_c;
  assign out_valid    = rst_n & ov_c;
  assign sample_we    = rst_n & we_c;
  assign sample_zero  = rst_n & zero_c;
  assign mac_clr      = rst_n & clr_c;
  assign mac_en       = rst_n & en_c;
  assign result_load  = rst_n & load_c;
  assign sample_waddr = waddr_c;
  assign coef_addr    = tap;
  assign busy         = (state != S_IDLE);

  // Adding N on underflow keeps the result in 0..N-1 for any N.
  assign sample_raddr = (tap <= newest) ? (newest - tap) : (newest - tap + AW'(N));

`ifdef FIR_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized + directed bench for fir_mac_sequencer against a timeline reference model.
module tb_fir_mac_sequencer;
  localparam int N  = 41;
  localparam int DP = 2;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, sample_we, sample_zero;
  logic          mac_clr, mac_en, result_load, busy;
  logic [AW-1:0] sample_waddr, sample_raddr, coef_addr;
`ifdef FIR_SEQ_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(N), .DP_LAT(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .sample_we(sample_we), .sample_zero(sample_zero),
    .sample_waddr(sample_waddr), .sample_raddr(sample_raddr),
    .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .result_load(result_load), .busy(busy)
`ifdef FIR_SEQ_PERF_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: cycles since reset release, and offset from the last accepted sample.
  int rel    = 0;
  bit pend   = 1'b0;
  int hs_cyc = 0;
  int n_acc  = 0;
  int newest = 0;
  int m_stall = 0;

  always @(negedge clk) begin
    int e_rdy, e_ov, e_we, e_zero, e_waddr, e_en, e_clr, e_coef, e_raddr, e_load, e_busy, d;
    bit accept;
    e_rdy = 0; e_ov = 0; e_we = 0; e_zero = 0; e_waddr = 0; e_en = 0; e_clr = 0;
    e_coef = 0; e_raddr = 0; e_load = 0; e_busy = 1; accept = 1'b0;
    if (!rst_n) begin
      rel = 0; pend = 1'b0; n_acc = 0; m_stall = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_mac_clr", mac_clr, 0);
      check("rst_result_load", result_load, 0);
      check("rst_sample_we", sample_we, 0);
    end else begin
      rel++;
      if (rel <= N) begin
        e_we = 1; e_zero = 1; e_waddr = rel - 1;
      end else if (!pend) begin
        e_busy = 0; e_rdy = 1; accept = in_valid;
      end else begin
        d = rel - hs_cyc;
        if (d <= N) begin
          e_en = 1; e_coef = d - 1; e_clr = (d == 1);
          e_raddr = ((newest - (d - 1)) % N + N) % N;
        end else if (d <= N + DP) begin
          e_load = (d == N + DP);
        end else begin
          e_ov = 1; e_rdy = out_ready;
          if (out_ready) begin
            pend = 1'b0; accept = in_valid;
          end
        end
      end
      if (accept) begin
        e_we = 1; e_waddr = n_acc % N;
        newest = n_acc % N; n_acc++; pend = 1'b1; hs_cyc = rel;
      end
      check("in_ready", in_ready, e_rdy);
      check("out_valid", out_valid, e_ov);
      check("sample_we", sample_we, e_we);
      check("sample_zero", sample_zero, e_zero);
      check("mac_en", mac_en, e_en);
      check("mac_clr", mac_clr, e_clr);
      check("result_load", result_load, e_load);
      check("busy", busy, e_busy);
      if (e_we != 0) check("sample_waddr", sample_waddr, e_waddr);
      if (e_en != 0) begin
        check("coef_addr", coef_addr, e_coef);
        check("sample_raddr", sample_raddr, e_raddr);
      end
`ifdef FIR_SEQ_PERF_EN
      check("stall_cnt", stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
`endif
      if (in_valid && e_rdy == 0) m_stall++;
    end
  end

  task automatic step(input bit v, input bit r);
    @(posedge clk); #1;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 300;
    step(1'b0, 1'b1);
    while (pend && budget > 0) begin
      step(1'b0, 1'b1);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    // INIT sweep with upstream already waiting, then 43 back-to-back samples
    repeat (N + 43 * (N + DP + 1)) step(1'b1, 1'b1);
    // long HOLD stall, then simultaneous result drain and new sample
    repeat (150) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
    repeat (1500) step($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
    // reset in the middle of RUN at tap 20
    wait_idle();
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    do_reset(2);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (N) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (60) step(1'b0, 1'b1);
`ifdef FIR_SEQ_PERF_EN
    // drive the stall counter into saturation
    wait_idle();
    repeat (70100) step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameters SHALL be: N, default 41, number of filter taps; DP_LAT, default 2, cycles from mac_en to an accumulated product in the MAC; AW, default $clog2(N), address width.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  rising-edge clock, sole clock domain.
  rst_n  in  1  synchronous active-low reset.
  in_valid  in  1  upstream sample valid.
  in_ready  out  1  sequencer accepts sample.
  out_valid  out  1  filtered result available.
  out_ready  in  1  downstream accepts result.
  sample_we  out  1  sample RAM write strobe.
  sample_zero  out  1  write zero instead of input data.
  sample_waddr  out  AW  sample RAM write address.
  sample_raddr  out  AW  sample RAM read address.
  coef_addr  out  AW  coefficient ROM address.
  mac_clr  out  1  restart accumulation with this product.
  mac_en  out  1  accumulate product this cycle.
  result_load  out  1  latch accumulator into output register.
  busy  out  1  high in any state except IDLE.
REQ-003 One clock; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 FSM states SHALL be INIT, IDLE, RUN, DRAIN and HOLD.
REQ-005 INIT SHALL assert sample_we=1 and sample_zero=1 for N cycles, with sample_waddr stepping 0..N-1, then move to IDLE.
REQ-006 in_ready SHALL be 1 in IDLE, and 1 in HOLD only while out_ready=1; it SHALL be 0 otherwise.
REQ-007 A handshake (in_valid&in_ready) SHALL assert sample_we with sample_waddr=wptr, advance wptr modulo N (N-1 wraps to 0) and enter RUN.
REQ-008 RUN SHALL last exactly N cycles with tap k=0..N-1: mac_en=1, coef_addr=k, sample_raddr=(newest - k) mod N, and mac_clr=1 only at k=0.
REQ-009 DRAIN SHALL last DP_LAT cycles, and result_load SHALL pulse in the last DRAIN cycle.
REQ-010 HOLD SHALL assert out_valid until out_ready=1.
REQ-011 Latency SHALL be: handshake in cycle t, out_valid=1 from cycle t+N+DP_LAT+1.
REQ-012 A simultaneous HOLD-exit and new input handshake SHALL go directly to RUN with no IDLE cycle.
REQ-013 A HOLD exit without an input handshake SHALL go to IDLE.
REQ-014 in_valid while in_ready=0 SHALL be ignored without loss; upstream holds the sample.
REQ-015 All address arithmetic SHALL be modulo N with no out-of-range value ever driven, including when N is not a power of two.

Reset
REQ-016 While rst_n=0 at a clock edge, the block SHALL set state=INIT, wptr=0 and tap counter=0.
REQ-017 During reset, in_ready, out_valid, mac_en, mac_clr, result_load and sample_we SHALL all be 0.
REQ-018 Reset asserted mid-RUN, mid-DRAIN or mid-HOLD SHALL abort the result with no result_load pulse, and SHALL rerun the INIT zero sweep.

Configuration
REQ-019 With FIR_SEQ_PERF_EN defined, the block SHALL add output stall_cnt [15:0], a saturating count of cycles with in_valid=1 and in_ready=0.
REQ-020 With FIR_SEQ_PERF_EN defined, stall_cnt SHALL be cleared by reset and SHALL hold at 16'hFFFF.
REQ-021 Without FIR_SEQ_PERF_EN, the stall_cnt port and its counter SHALL NOT exist.

Structure
REQ-022 Package fir_seq_pkg SHALL hold the FSM state enum, the default tap count (41) and the default DP_LAT.
REQ-023 The block SHALL instantiate sub-module fir_seq_mod_ctr, a parameterised modulo-N up counter with enable and clear, for wptr, the tap index and the INIT sweep.

Verification
REQ-024 Reset release, N=41 -> 41 cycles of sample_we=1, sample_zero=1, addresses 0..40; in_ready rises on cycle 42.
REQ-025 One sample, DP_LAT=2, out_ready=1 -> RUN raddr sequence 0,40,39..1 with coef 0..40; result_load pulses once; out_valid at t+44.
REQ-026 42 back-to-back samples -> wptr wraps 40->0; the 42nd RUN starts at raddr 0, then 40.
REQ-027 out_ready held 0 for 100 cycles in HOLD -> out_valid stays 1, in_ready 0, no extra mac_en; out_ready=1 together with in_valid=1 -> RUN next cycle.
REQ-028 rst_n=0 at tap 20 of RUN -> no result_load, INIT sweep repeats, wptr=0.
REQ-029 FIR_SEQ_PERF_EN defined, in_valid held 1 through 3 samples -> stall_cnt equals the total in_ready=0 cycles; forced 70000-cycle stall -> stall_cnt saturates at 65535.
